// File: rtl/load_data_unit.sv
// Load data unit: accepts a byte-addressed load, issues one word-aligned read,
// then extracts and sign/zero-extends the addressed lane, flagging exceptions.
module load_data_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  input  logic        req_signed,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        ld_valid,
  input  logic        ld_ready,
  output logic [31:0] ld_data,
  output logic [1:0]  ld_status
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    LD_WORD = 3'd0,
    LD_HALF = 3'd1,
    LD_BYTE = 3'd2
  } ld_type_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_MISALIGN = 2'b01,
    ST_TIMEOUT  = 2'b10,
    ST_ILLEGAL  = 2'b11
  } status_e;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       off_q;
  logic [2:0]       type_q;
  logic             sign_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  status_e          status_q;

  logic illegal;
  logic misaligned;
  logic terminal;

  assign illegal    = (req_type > 3'd2);
  assign misaligned = ((req_type == LD_HALF) && req_addr[0]) ||
                      ((req_type == LD_WORD) && (req_addr[1:0] != 2'b00));
  assign terminal   = (cnt_q == TERM);

  assign mem_addr  = addr_q;
  assign ld_data   = data_q;
  assign ld_status = status_q;

  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [2:0]  t,
                                          input logic [1:0]  off,
                                          input logic        sgn);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = off[1] ? w[31:16] : w[15:0];
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (t)
      LD_HALF: r = {{16{sgn & h[15]}}, h};
      LD_BYTE: r = {{24{sgn & b[7]}}, b};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    ld_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (illegal || misaligned) ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mem_rd_en = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid || terminal) state_d = S_RESP;
      end
      S_RESP: begin
        ld_valid = 1'b1;
        if (ld_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      off_q    <= '0;
      type_q   <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      status_q <= ST_OK;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            off_q  <= req_addr[1:0];
            type_q <= req_type;
            sign_q <= req_signed;
            addr_q <= {req_addr[31:2], 2'b00};
            if (illegal) begin
              data_q   <= '0;
              status_q <= ST_ILLEGAL;
            end else if (misaligned) begin
              data_q   <= '0;
              status_q <= ST_MISALIGN;
            end
          end
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          // rvalid is checked first so it wins over the terminal count
          if (mem_rvalid) begin
            data_q   <= extract(mem_rdata, type_q, off_q, sign_q);
            status_q <= ST_OK;
          end else if (terminal) begin
            data_q   <= '0;
            status_q <= ST_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_data_unit.sv
// Directed self-checking bench for load_data_unit: lane extraction, exceptions,
// timeout boundary, response stall and reset abort.
module tb_load_data_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic        req_signed;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic [1:0]  ld_status;

  int unsigned compared;
  int unsigned mismatched;

  load_data_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_type   (req_type),
    .req_signed (req_signed),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_status  (ld_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accepts a load, returns rvalid after dly idle WAIT cycles, checks the result.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] t,
                         input logic s, input logic [31:0] rd, input int unsigned dly,
                         input logic [31:0] exp);
    req_valid = 1'b1; req_addr = a; req_type = t; req_signed = s;
    tick;
    req_valid = 1'b0;
    chk({tag, ".rd_en"}, {31'd0, mem_rd_en}, 32'd1);
    chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, ".rdy_busy"}, {31'd0, req_ready}, 32'd0);
    tick;
    chk({tag, ".rd_en_off"}, {31'd0, mem_rd_en}, 32'd0);
    for (int unsigned i = 0; i < dly; i++) begin
      chk({tag, ".wait_valid"}, {31'd0, ld_valid}, 32'd0);
      tick;
    end
    chk({tag, ".pre_valid"}, {31'd0, ld_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk({tag, ".valid"}, {31'd0, ld_valid}, 32'd1);
    chk({tag, ".data"}, ld_data, exp);
    chk({tag, ".status"}, {30'd0, ld_status}, 32'd0);
    ld_ready = 1'b1;
    tick;
    ld_ready = 1'b0;
    chk({tag, ".done_valid"}, {31'd0, ld_valid}, 32'd0);
    chk({tag, ".done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_exc(input string tag, input logic [31:0] a, input logic [2:0] t,
                        input logic [1:0] exp_status);
    req_valid = 1'b1; req_addr = a; req_type = t; req_signed = 1'b1;
    tick;
    req_valid = 1'b0;
    chk({tag, ".rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({tag, ".valid"}, {31'd0, ld_valid}, 32'd1);
    chk({tag, ".status"}, {30'd0, ld_status}, {30'd0, exp_status});
    chk({tag, ".data"}, ld_data, 32'd0);
    ld_ready = 1'b1;
    tick;
    ld_ready = 1'b0;
    chk({tag, ".done_valid"}, {31'd0, ld_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".ld_valid"}, {31'd0, ld_valid}, 32'd0);
    chk({tag, ".ld_data"}, ld_data, 32'd0);
    chk({tag, ".ld_status"}, {30'd0, ld_status}, 32'd0);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_type = '0; req_signed = 1'b0;
    mem_rdata = '0; mem_rvalid = 1'b0; ld_ready = 1'b0;
    tick; tick; tick;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick;

    // lane extraction
    do_load("lw",      32'h0000_0100, 3'd0, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    do_load("lb_s",    32'h0000_0103, 3'd2, 1'b1, 32'h8012_3456, 0, 32'hFFFF_FF80);
    do_load("lbu",     32'h0000_0103, 3'd2, 1'b0, 32'h8012_3456, 0, 32'h0000_0080);
    do_load("lh_s_hi", 32'h0000_0102, 3'd1, 1'b1, 32'h7FFF_8000, 0, 32'h0000_7FFF);
    do_load("lh_s_lo", 32'h0000_0100, 3'd1, 1'b1, 32'h7FFF_8000, 0, 32'hFFFF_8000);
    do_load("lhu_lo",  32'h0000_0100, 3'd1, 1'b0, 32'h7FFF_8000, 2, 32'h0000_8000);
    do_load("lb_s1",   32'h0000_0101, 3'd2, 1'b1, 32'h0000_F700, 3, 32'hFFFF_FFF7);
    do_load("lbu2",    32'h0000_0102, 3'd2, 1'b0, 32'h00AB_0000, 1, 32'h0000_00AB);
    do_load("lw_sgn",  32'h0000_1F04, 3'd0, 1'b1, 32'h8000_0001, 0, 32'h8000_0001);

    // exceptions, no memory access
    do_exc("lh_mis",  32'h0000_0101, 3'd1, 2'b01);
    do_exc("lw_mis",  32'h0000_0102, 3'd0, 2'b01);
    do_exc("type5",   32'h0000_0100, 3'd5, 2'b11);
    do_exc("type3",   32'h0000_0101, 3'd3, 2'b11);

    // timeout: 16 WAIT cycles without rvalid
    req_valid = 1'b1; req_addr = 32'h0000_0200; req_type = 3'd0; req_signed = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    repeat (15) tick;
    chk("to.last_wait_valid", {31'd0, ld_valid}, 32'd0);
    chk("to.addr_held", mem_addr, 32'h0000_0200);
    tick;
    chk("to.valid", {31'd0, ld_valid}, 32'd1);
    chk("to.status", {30'd0, ld_status}, 32'd2);
    chk("to.data", ld_data, 32'd0);
    ld_ready = 1'b1;
    tick;
    ld_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick;
    mem_rvalid = 1'b0;
    chk("late.valid", {31'd0, ld_valid}, 32'd0);
    chk("late.ready", {31'd0, req_ready}, 32'd1);
    chk("late.data", ld_data, 32'd0);
    chk("late.status", {30'd0, ld_status}, 32'd2);

    // rvalid on the terminal count still succeeds
    req_valid = 1'b1; req_addr = 32'h0000_0240; req_type = 3'd0;
    tick;
    req_valid = 1'b0;
    tick;
    repeat (15) tick;
    chk("tc.pre_valid", {31'd0, ld_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick;
    mem_rvalid = 1'b0;
    chk("tc.valid", {31'd0, ld_valid}, 32'd1);
    chk("tc.status", {30'd0, ld_status}, 32'd0);
    chk("tc.data", ld_data, 32'hCAFE_F00D);
    ld_ready = 1'b1;
    tick;
    ld_ready = 1'b0;

    // consumer stall: result held, no accept while in RESP
    req_valid = 1'b1; req_addr = 32'h0000_0300; req_type = 3'd0;
    tick;
    req_valid = 1'b0;
    tick;
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    tick;
    mem_rvalid = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_0301; req_type = 3'd1;
    for (int unsigned i = 0; i < 4; i++) begin
      chk("stall.valid", {31'd0, ld_valid}, 32'd1);
      chk("stall.data", ld_data, 32'h1122_3344);
      chk("stall.status", {30'd0, ld_status}, 32'd0);
      chk("stall.req_ready", {31'd0, req_ready}, 32'd0);
      tick;
    end
    ld_ready = 1'b1;
    tick;
    ld_ready = 1'b0;
    chk("stall.idle_ready", {31'd0, req_ready}, 32'd1);
    chk("stall.idle_valid", {31'd0, ld_valid}, 32'd0);
    tick;
    req_valid = 1'b0;
    chk("stall.next_valid", {31'd0, ld_valid}, 32'd1);
    chk("stall.next_status", {30'd0, ld_status}, 32'd1);
    ld_ready = 1'b1;
    tick;
    ld_ready = 1'b0;

    // reset in WAIT aborts the load
    do_load("pre_rst", 32'h0000_0500, 3'd0, 1'b0, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5);
    do_exc("pre_rst_mis", 32'h0000_0503, 3'd1, 2'b01);
    do_load("pre_rst2", 32'h0000_0504, 3'd0, 1'b0, 32'h5A5A_5A5A, 0, 32'h5A5A_5A5A);
    req_valid = 1'b1; req_addr = 32'h0000_0400; req_type = 3'd0;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("rst.in_wait_addr", mem_addr, 32'h0000_0400);
    reset = 1'b1;
    tick;
    check_reset_outputs("rst_wait");
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick;
    tick;
    mem_rvalid = 1'b0;
    chk("rst.after_valid", {31'd0, ld_valid}, 32'd0);
    chk("rst.after_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.after_data", ld_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
